ibex_pext_mac32: RTL and testbench

- Iterative signed 32x32 multiply-accumulate engine for the Zpn ops MADDR32, MSUBR32, KMMAC, KMMACu, KMMSB and KMMSBu.
- Sits in the EX stage, directly downstream of the Pext control decoder. It consumes that decoder's alu_sub, rounding and zpn_instr outputs.
- Reuses one 17x17 signed multiplier over up to four cycles, then accumulates with rd and saturates if required.

---
 rtl/ibex_pext_mac32.sv | 198 +++++++++++++++++++
 tb/tb_ibex_pext_mac32.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ibex_pext_mac32.sv
// ibex_pext_mac32: iterative signed 32x32 multiply-accumulate for the Zpn ops
// MADDR32/MSUBR32 (low word, wrapping) and KMMAC/KMMACu/KMMSB/KMMSBu (high
// word, optional rounding, saturating). One 17x17 signed multiplier is reused
// over up to four partial-product cycles, then rd is added or subtracted.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   en_i, kill_i             request (held until valid_o) and synchronous flush
//   high_i                   1 = high-word saturating op, 0 = low-word wrapping op
//   alu_sub_i, rounding_i    decoder controls (bit 0 of alu_sub_i selects subtract)
//   op_a_i, op_b_i, op_c_i   rs1, rs2, rd
//   busy_o                   engine not idle
//   valid_o, result_o, ov_o  one-cycle result pulse, result, saturation flag
module ibex_pext_mac32 #(
    parameter int unsigned ACC_W = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        kill_i,
    input  logic        high_i,
    input  logic [1:0]  alu_sub_i,
    input  logic        rounding_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [31:0] op_c_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic        ov_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MUL_W  = 17;
    localparam int unsigned PROD_W = 2 * MUL_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PP0  = 3'd1,
        PP1  = 3'd2,
        PP2  = 3'd3,
        PP3  = 3'd4,
        ACC  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic                high_q, high_d, sub_q, sub_d, rnd_q, rnd_d;
    logic [ACC_W-1:0]    acc_q, acc_d;

    logic signed [MUL_W-1:0]  mul_a, mul_b;
    logic signed [PROD_W-1:0] prod;
    logic [ACC_W-1:0]         pp_ext, pp_shift;
    logic [DATA_W-1:0]        lo_sum, h;
    logic [DATA_W:0]          c_ext, h_ext, s;

    // Only bit 0 of alu_sub_i carries meaning for these ops.
    logic unused_sub_hi;
    assign unused_sub_hi = alu_sub_i[1];

    // Per-state operand halves; low halves zero-extend, high halves sign-extend.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state_q)
            PP0: begin
                mul_a = {1'b0, a_q[15:0]};
                mul_b = {1'b0, b_q[15:0]};
            end
            PP1: begin
                mul_a = {1'b0, a_q[15:0]};
                mul_b = {b_q[31], b_q[31:16]};
            end
            PP2: begin
                mul_a = {a_q[31], a_q[31:16]};
                mul_b = {1'b0, b_q[15:0]};
            end
            PP3: begin
                mul_a = {a_q[31], a_q[31:16]};
                mul_b = {b_q[31], b_q[31:16]};
            end
            default: ;
        endcase
    end

    assign prod   = mul_a * mul_b;
    assign pp_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    // Align the partial product to its weight.
    always_comb begin
        pp_shift = pp_ext;
        unique case (state_q)
            PP1, PP2: pp_shift = pp_ext << 16;
            PP3:      pp_shift = pp_ext << 32;
            default:  pp_shift = pp_ext;
        endcase
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        high_d  = high_q;
        sub_d   = sub_q;
        rnd_d   = rnd_q;
        acc_d   = acc_q;

        if (state_q == IDLE) begin
            if (en_i && !kill_i) begin
                a_d     = op_a_i;
                b_d     = op_b_i;
                c_d     = op_c_i;
                high_d  = high_i;
                sub_d   = alu_sub_i[0];
                rnd_d   = rounding_i;
                acc_d   = '0;
                state_d = PP0;
            end
        end else if (kill_i || !en_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                PP0: begin
                    acc_d   = acc_q + pp_shift;
                    state_d = PP1;
                end
                PP1: begin
                    acc_d   = acc_q + pp_shift;
                    state_d = PP2;
                end
                PP2: begin
                    // a_hi*b_hi only lands at bit 32 and up, so low-word ops skip it.
                    acc_d   = acc_q + pp_shift;
                    state_d = high_q ? PP3 : ACC;
                end
                PP3: begin
                    acc_d   = acc_q + pp_shift;
                    state_d = ACC;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Result datapath; adding 2^31 carries into bit 32 exactly when acc[31] is set.
    always_comb begin
        lo_sum = sub_q ? (c_q - acc_q[31:0]) : (c_q + acc_q[31:0]);
        h      = acc_q[63:32] + DATA_W'(rnd_q & acc_q[31]);
        c_ext  = {c_q[31], c_q};
        h_ext  = {h[31], h};
        s      = sub_q ? (c_ext - h_ext) : (c_ext + h_ext);
    end

    // Outputs follow the state directly; valid only in an unkilled ACC cycle.
    always_comb begin
        busy_o   = (state_q != IDLE);
        valid_o  = 1'b0;
        result_o = '0;
        ov_o     = 1'b0;
        if (state_q == ACC && en_i && !kill_i) begin
            valid_o = 1'b1;
            if (!high_q) begin
                result_o = lo_sum;
            end else if (s[32] != s[31]) begin
                ov_o     = 1'b1;
                result_o = s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                result_o = s[31:0];
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            high_q  <= 1'b0;
            sub_q   <= 1'b0;
            rnd_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            high_q  <= high_d;
            sub_q   <= sub_d;
            rnd_q   <= rnd_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_ibex_pext_mac32.sv
// tb_ibex_pext_mac32: directed and randomized checks of ibex_pext_mac32
// against an arithmetic reference model of the Zpn MAC ops.
module tb_ibex_pext_mac32;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        en_i, kill_i, high_i, rounding_i;
    logic [1:0]  alu_sub_i;
    logic [31:0] op_a_i, op_b_i, op_c_i;
    logic        busy_o, valid_o, ov_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_errors = 0;

    ibex_pext_mac32 dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .kill_i     (kill_i),
        .high_i     (high_i),
        .alu_sub_i  (alu_sub_i),
        .rounding_i (rounding_i),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .op_c_i     (op_c_i),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .result_o   (result_o),
        .ov_o       (ov_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: full signed product, then the op's rule in plain arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c, input logic hi,
                                  input logic sub, input logic rnd,
                                  output logic [31:0] r, output logic ov);
        longint p, h, s, cs;
        logic [63:0] pu;
        p  = longint'($signed(a)) * longint'($signed(b));
        pu = p;
        ov = 1'b0;
        if (!hi) begin
            r = sub ? (c - pu[31:0]) : (c + pu[31:0]);
        end else begin
            if (rnd) p = p + 64'sd2147483648;
            h  = p >>> 32;
            cs = longint'($signed(c));
            s  = sub ? (cs - h) : (cs + h);
            if (s > 64'sd2147483647) begin
                r = 32'h7FFF_FFFF; ov = 1'b1;
            end else if (s < -64'sd2147483648) begin
                r = 32'h8000_0000; ov = 1'b1;
            end else begin
                r = 32'(s);
            end
        end
    endfunction

    task automatic idle_inputs();
        en_i = 1'b0; kill_i = 1'b0; high_i = 1'b0; rounding_i = 1'b0;
        alu_sub_i = 2'b00; op_a_i = '0; op_b_i = '0; op_c_i = '0;
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic hi, input logic [1:0] sub, input logic rnd);
        @(posedge clk); #1;
        en_i = 1'b1; kill_i = 1'b0; op_a_i = a; op_b_i = b; op_c_i = c;
        high_i = hi; alu_sub_i = sub; rounding_i = rnd;
    endtask

    // Runs one op, scrambling operand inputs after the start cycle, and
    // checks latency, result and ov.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic hi, input logic [1:0] sub,
                          input logic rnd);
        logic [31:0] er, got_r;
        logic        eov, got_ov;
        int          lat;
        model(a, b, c, hi, sub[0], rnd, er, eov);
        start(a, b, c, hi, sub, rnd);
        lat = 99; got_r = 'x; got_ov = 1'bx;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (valid_o) begin
                lat = cyc; got_r = result_o; got_ov = ov_o;
                break;
            end
            @(posedge clk); #1;
            op_a_i = $urandom; op_b_i = $urandom; op_c_i = $urandom;
            high_i = 1'($urandom); rounding_i = 1'($urandom);
            alu_sub_i = 2'($urandom);
        end
        @(posedge clk); #1;
        idle_inputs();
        check({tag, "_lat"}, 32'(lat), hi ? 32'd5 : 32'd4);
        check({tag, "_res"}, got_r, er);
        check({tag, "_ov"}, 32'(got_ov), 32'(eov));
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h7FFF_FFFF;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        seen_valid;
        logic [1:0]  sub;
        rst_i = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_ov", 32'(ov_o), 32'd0);
        rst_i = 1'b0;

        run_op("madd", 32'd3, 32'd5, 32'd10, 1'b0, 2'b00, 1'b0);
        run_op("msub", 32'd3, 32'd5, 32'd10, 1'b0, 2'b11, 1'b0);
        run_op("kmmac_sat", 32'h4000_0000, 32'h4000_0000, 32'h7000_0000, 1'b1, 2'b00, 1'b0);
        run_op("kmmsb_r0", 32'h0001_0000, 32'h0000_8000, 32'd5, 1'b1, 2'b11, 1'b0);
        run_op("kmmsb_r1", 32'h0001_0000, 32'h0000_8000, 32'd5, 1'b1, 2'b11, 1'b1);
        run_op("kmmac_neg_r0", 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 2'b00, 1'b0);
        run_op("kmmac_neg_r1", 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 2'b00, 1'b1);
        run_op("kmmsb_sat", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 2'b11, 1'b0);
        run_op("kmmac_minmin", 32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 1'b1, 2'b00, 1'b1);

        // Flush during PP2: no result, idle next cycle, then a clean op.
        start(32'd2, 32'd7, 32'd1, 1'b0, 2'b00, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        kill_i = 1'b1;
        seen_valid = 1'b0;
        @(negedge clk);
        if (valid_o) seen_valid = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("kill_busy", 32'(busy_o), 32'd0);
        repeat (4) begin
            @(negedge clk);
            if (valid_o) seen_valid = 1'b1;
        end
        check("kill_novalid", 32'(seen_valid), 32'd0);
        run_op("after_kill", 32'd2, 32'd7, 32'd1, 1'b0, 2'b00, 1'b0);

        // Kill together with en in IDLE never starts the op.
        start(32'd9, 32'd9, 32'd9, 1'b1, 2'b00, 1'b0);
        kill_i = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("kill_idle_busy", 32'(busy_o), 32'd0);

        // Dropping en mid-op aborts it.
        start(32'd4, 32'd4, 32'd4, 1'b1, 2'b00, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        en_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("en_drop_busy", 32'(busy_o), 32'd0);
        idle_inputs();

        // Asynchronous reset during PP1.
        start(32'd123, 32'd456, 32'd789, 1'b1, 2'b00, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("pp1_busy", 32'(busy_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_valid", 32'(valid_o), 32'd0);
        check("arst_result", result_o, 32'd0);
        idle_inputs();
        @(posedge clk); #1;
        rst_i = 1'b0;
        run_op("after_rst", 32'd6, 32'd7, 32'd8, 1'b0, 2'b11, 1'b0);

        for (int i = 0; i < 40; i++) begin
            sub = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            run_op($sformatf("rand%0d", i), pick_operand(), pick_operand(), pick_operand(),
                   1'($urandom), sub, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
